// File: rtl/cpu_pkg.sv
// Shared widths, opcode encodings, instruction field positions and fetch states
// for the 16-bit RISC CPU.
package cpu_pkg;

    localparam int PC_W    = 8;
    localparam int INSTR_W = 16;

    localparam logic [3:0] OP_NOP = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_LDI = 4'b1001;
    localparam logic [3:0] OP_ST  = 4'b1011;
    localparam logic [3:0] OP_JMP = 4'b1100;
    localparam logic [3:0] OP_JZ  = 4'b1101;
    localparam logic [3:0] OP_HLT = 4'b1110;

    // Field positions: opcode = instr[15:12], imm = instr[7:0]
    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_predecode.sv
// Combinational predecode of the fetched word: spots JMP/HLT and picks the
// following program counter.
module fetch_predecode
    import cpu_pkg::*;
(
    input  logic [INSTR_W-1:0] instr,
    input  logic [PC_W-1:0]    pc,
    output logic               is_jmp,
    output logic               is_hlt,
    output logic [PC_W-1:0]    next_pc
);

    logic [3:0]      opcode;
    logic [PC_W-1:0] imm;
    logic            unused_fields;

    assign opcode        = instr[OPC_MSB:OPC_LSB];
    assign imm           = instr[IMM_MSB:IMM_LSB];
    assign unused_fields = ^instr[OPC_LSB-1:IMM_MSB+1];

    assign is_jmp = (opcode == OP_JMP);
    assign is_hlt = (opcode == OP_HLT);

    // HLT parks the pc on itself; JZ is left to execute and falls through here
    always_comb begin
        next_pc = pc + PC_W'(1);
        if (is_hlt) begin
            next_pc = pc;
        end else if (is_jmp) begin
            next_pc = imm;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the pc, captures ROM words into the
// instruction register and hands them to decode over a valid/ready handshake.
module fetch_unit
    import cpu_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    output logic [15:0]         imem_addr,
    input  logic [INSTR_W-1:0]  imem_instr,
    output logic [INSTR_W-1:0]  ir,
    output logic [PC_W-1:0]     ir_pc,
    output logic                ir_valid,
    input  logic                id_ready,
    input  logic                redirect_valid,
    input  logic [PC_W-1:0]     redirect_target,
    output logic                halted,
    output logic [15:0]         fetch_count
);

    fetch_state_t    state;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] next_pc;
    logic            is_jmp;
    logic            is_hlt;
    logic            advance;
    logic            accepted;

    fetch_predecode u_predecode (
        .instr   (imem_instr),
        .pc      (pc),
        .is_jmp  (is_jmp),
        .is_hlt  (is_hlt),
        .next_pc (next_pc)
    );

    assign imem_addr = {{(16-PC_W){1'b0}}, pc};
    assign halted    = (state == HALTED);
    assign advance   = !ir_valid || id_ready;
    assign accepted  = ir_valid && id_ready && !redirect_valid;

    // Redirect outranks both stall and halt; reset outranks redirect
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            pc          <= '0;
            ir          <= '0;
            ir_pc       <= '0;
            ir_valid    <= 1'b0;
            fetch_count <= '0;
        end else begin
            if (accepted && fetch_count != 16'hFFFF) begin
                fetch_count <= fetch_count + 16'd1;
            end
            if (redirect_valid) begin
                pc       <= redirect_target;
                ir_valid <= 1'b0;
                state    <= RUN;
            end else begin
                case (state)
                    RUN: begin
                        if (advance) begin
                            ir       <= imem_instr;
                            ir_pc    <= pc;
                            ir_valid <= 1'b1;
                            pc       <= next_pc;
                            if (is_hlt) begin
                                state <= HALTED;
                            end
                        end
                    end
                    HALTED: begin
                        if (id_ready) begin
                            ir_valid <= 1'b0;
                        end
                    end
                    default: state <= RUN;
                endcase
            end
        end
    end

    logic unused_jmp;
    assign unused_jmp = is_jmp;

endmodule
